// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU operation sequencer:
//   - default ALU operand / opcode / result widths
//   - opcode encodings of the 4-bit ALU (ascending sweep order)
//   - sequencer FSM state encoding
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_OPND_W = 4;
  localparam int ALU_SEL_W  = 3;
  localparam int ALU_OUT_W  = 8;
  localparam int ALU_N_OPS  = 2 ** ALU_SEL_W;

  localparam logic [ALU_SEL_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_SEL_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_SEL_W-1:0] OP_MUL = 3'd2;
  localparam logic [ALU_SEL_W-1:0] OP_DIV = 3'd3;
  localparam logic [ALU_SEL_W-1:0] OP_LSL = 3'd4;
  localparam logic [ALU_SEL_W-1:0] OP_LSR = 3'd5;
  localparam logic [ALU_SEL_W-1:0] OP_AND = 3'd6;
  localparam logic [ALU_SEL_W-1:0] OP_OR  = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DRIVE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_DONE  = 3'd4
  } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer_if
// Bus between the sequencer and the combinational ALU.
//   alu_a, alu_b  : operands to the ALU
//   alu_sel       : opcode to the ALU
//   alu_out       : ALU result
//   alu_cflag     : ALU carry flag
//   alu_zflag     : ALU zero flag
// Modports: master = sequencer side, slave = ALU side.
// ---------------------------------------------------------------------------
interface alu_op_sequencer_if
  import alu_pkg::*;
#(
  parameter int OPND_W = ALU_OPND_W,
  parameter int SEL_W  = ALU_SEL_W,
  parameter int OUT_W  = ALU_OUT_W
) ();

  logic [OPND_W-1:0] alu_a;
  logic [OPND_W-1:0] alu_b;
  logic [SEL_W-1:0]  alu_sel;
  logic [OUT_W-1:0]  alu_out;
  logic              alu_cflag;
  logic              alu_zflag;

  modport master (
    output alu_a, alu_b, alu_sel,
    input  alu_out, alu_cflag, alu_zflag
  );

  modport slave (
    input  alu_a, alu_b, alu_sel,
    output alu_out, alu_cflag, alu_zflag
  );

endinterface

// File: rtl/alu_next_op.sv
// ---------------------------------------------------------------------------
// alu_next_op
// Combinational priority finder: returns the lowest enabled opcode strictly
// above idx (or at/above idx when incl=1), plus a flag when none exists.
//   mask     : enabled-opcode bitmap
//   idx      : reference opcode
//   incl     : 1 = idx itself is a candidate
//   next_idx : lowest qualifying opcode (0 when none)
//   none     : no qualifying opcode
// ---------------------------------------------------------------------------
module alu_next_op
  import alu_pkg::*;
#(
  parameter int SEL_W = ALU_SEL_W
) (
  input  logic [2**SEL_W-1:0] mask,
  input  logic [SEL_W-1:0]    idx,
  input  logic                incl,
  output logic [SEL_W-1:0]    next_idx,
  output logic                none
);

  localparam int N = 2 ** SEL_W;

  logic [N-1:0] cand;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      localparam logic [SEL_W-1:0] K = SEL_W'(gi);
      assign cand[gi] = mask[gi] && ((K > idx) || (incl && (K == idx)));
    end
  endgenerate

  // Scan downward so the lowest candidate is the last one written.
  always_comb begin
    next_idx = '0;
    none     = 1'b1;
    for (int k = N - 1; k >= 0; k--) begin
      if (cand[k]) begin
        next_idx = SEL_W'(k);
        none     = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// alu_op_sequencer
// On an accepted start, latches one operand pair and steps the ALU through
// every enabled opcode in ascending order, waiting SETTLE_CYC cycles per
// opcode and capturing {out, cflag, zflag} into a buffer indexed by opcode.
//   clk, rst       : clock, synchronous active-high reset
//   start          : sweep request, accepted only in IDLE
//   a_in, b_in     : operands, sampled on accepted start
//   op_mask        : enabled opcodes, sampled on accepted start
//   alu            : ALU bus (master side)
//   busy, done     : sweep in progress / one-cycle end-of-sweep pulse
//   zero_cnt       : captured results with zflag=1 in last sweep
//   rd_idx         : buffer read index
//   rd_data/cflag/zflag/valid : combinational buffer read port
// ---------------------------------------------------------------------------
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int OPND_W     = ALU_OPND_W,
  parameter int SEL_W      = ALU_SEL_W,
  parameter int OUT_W      = ALU_OUT_W,
  parameter int SETTLE_CYC = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [OPND_W-1:0]   a_in,
  input  logic [OPND_W-1:0]   b_in,
  input  logic [2**SEL_W-1:0] op_mask,
  alu_op_sequencer_if.master  alu,
  output logic                busy,
  output logic                done,
  output logic [SEL_W:0]      zero_cnt,
  input  logic [SEL_W-1:0]    rd_idx,
  output logic [OUT_W-1:0]    rd_data,
  output logic                rd_cflag,
  output logic                rd_zflag,
  output logic                rd_valid
);

  localparam int N     = 2 ** SEL_W;
  localparam int CNT_W = 4;

  seq_state_t        state_reg, state_next;
  logic [OPND_W-1:0] a_reg, b_reg;
  logic [SEL_W-1:0]  sel_reg;
  logic [N-1:0]      mask_reg;
  logic [N-1:0]      valid_reg;
  logic [SEL_W:0]    zero_cnt_reg;
  logic              busy_reg;
  logic [CNT_W-1:0]  cnt_reg;

  // Result word layout: {out, cflag, zflag}
  logic [OUT_W+1:0]  res_mem [N];

  logic [N-1:0]      find_mask;
  logic [SEL_W-1:0]  find_idx;
  logic              find_incl;
  logic [SEL_W-1:0]  nx_idx;
  logic              nx_none;

  // In IDLE the finder looks for the lowest opcode of the incoming mask;
  // during the sweep it looks for the next opcode above the current one.
  assign find_mask = (state_reg == ST_IDLE) ? op_mask : mask_reg;
  assign find_idx  = (state_reg == ST_IDLE) ? '0 : sel_reg;
  assign find_incl = (state_reg == ST_IDLE);

  alu_next_op #(.SEL_W(SEL_W)) u_next_op (
    .mask     (find_mask),
    .idx      (find_idx),
    .incl     (find_incl),
    .next_idx (nx_idx),
    .none     (nx_none)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = nx_none ? ST_DONE : ST_DRIVE;
      ST_DRIVE: state_next = (SETTLE_CYC == 0) ? ST_CAPT : ST_WAIT;
      ST_WAIT:  if (cnt_reg == CNT_W'(1)) state_next = ST_CAPT;
      ST_CAPT:  state_next = nx_none ? ST_DONE : ST_DRIVE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg        <= '0;
      b_reg        <= '0;
      sel_reg      <= '0;
      mask_reg     <= '0;
      valid_reg    <= '0;
      zero_cnt_reg <= '0;
      busy_reg     <= 1'b0;
      cnt_reg      <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg        <= a_in;
            b_reg        <= b_in;
            mask_reg     <= op_mask;
            valid_reg    <= '0;
            zero_cnt_reg <= '0;
            busy_reg     <= 1'b1;
            if (!nx_none) sel_reg <= nx_idx;
          end
        end
        ST_DRIVE: cnt_reg <= CNT_W'(SETTLE_CYC);
        ST_WAIT:  cnt_reg <= cnt_reg - CNT_W'(1);
        ST_CAPT: begin
          valid_reg[sel_reg] <= 1'b1;
          zero_cnt_reg       <= zero_cnt_reg + {{SEL_W{1'b0}}, alu.alu_zflag};
          if (!nx_none) sel_reg <= nx_idx;
        end
        ST_DONE:  busy_reg <= 1'b0;
        default:  ;
      endcase
    end
  end

  // Buffer contents need no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (state_reg == ST_CAPT) res_mem[sel_reg] <= {alu.alu_out, alu.alu_cflag, alu.alu_zflag};
  end

  logic [OUT_W+1:0] rd_word;
  assign rd_word  = res_mem[rd_idx];
  assign rd_valid = valid_reg[rd_idx];
  assign rd_data  = rd_valid ? rd_word[OUT_W+1:2] : '0;
  assign rd_cflag = rd_valid & rd_word[1];
  assign rd_zflag = rd_valid & rd_word[0];

  assign alu.alu_a   = a_reg;
  assign alu.alu_b   = b_reg;
  assign alu.alu_sel = sel_reg;
  assign busy        = busy_reg;
  assign done        = (state_reg == ST_DONE);
  assign zero_cnt    = zero_cnt_reg;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_op_sequencer
// Two sequencer instances (SETTLE_CYC=1 and 3), each driving a behavioural
// 4-bit ALU. Table-driven sweeps with a result scoreboard, plus hand-written
// sequences for mid-sweep restart and mid-sweep reset.
// ---------------------------------------------------------------------------
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start1, start3;
  logic [3:0] a_in, b_in;
  logic [7:0] op_mask;
  logic [2:0] rd_idx;
  logic       busy1, done1, busy3, done3;
  logic [3:0] zc1, zc3;
  logic [7:0] rdd1, rdd3;
  logic       rdc1, rdz1, rdv1, rdc3, rdz3, rdv3;

  alu_op_sequencer_if ifc1 ();
  alu_op_sequencer_if ifc3 ();

  alu_op_sequencer #(.SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a_in(a_in), .b_in(b_in),
    .op_mask(op_mask), .alu(ifc1), .busy(busy1), .done(done1),
    .zero_cnt(zc1), .rd_idx(rd_idx), .rd_data(rdd1), .rd_cflag(rdc1),
    .rd_zflag(rdz1), .rd_valid(rdv1)
  );

  alu_op_sequencer #(.SETTLE_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_in(a_in), .b_in(b_in),
    .op_mask(op_mask), .alu(ifc3), .busy(busy3), .done(done3),
    .zero_cnt(zc3), .rd_idx(rd_idx), .rd_data(rdd3), .rd_cflag(rdc3),
    .rd_zflag(rdz3), .rd_valid(rdv3)
  );

  // Behavioural model of the existing 4-bit ALU: returns {out, cflag, zflag}.
  function automatic logic [9:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                           input logic [2:0] sel);
    logic [7:0] r;
    logic       c;
    r = '0;
    c = 1'b0;
    case (sel)
      OP_ADD: begin r = {4'b0, a} + {4'b0, b}; c = r[4]; end
      OP_SUB: begin r = {4'b0, a - b}; c = (a < b); end
      OP_MUL: r = {4'b0, a} * {4'b0, b};
      OP_DIV: r = (b == 4'd0) ? 8'hFF : {4'b0, a / b};
      OP_LSL: begin r = {3'b0, a, 1'b0}; c = a[3]; end
      OP_LSR: begin r = {5'b0, a[3:1]}; c = a[0]; end
      OP_AND: r = {4'b0, a & b};
      OP_OR:  r = {4'b0, a | b};
      default: r = '0;
    endcase
    return {r, c, (r == 8'd0)};
  endfunction

  always_comb begin
    {ifc1.alu_out, ifc1.alu_cflag, ifc1.alu_zflag} = alu_model(ifc1.alu_a, ifc1.alu_b, ifc1.alu_sel);
    {ifc3.alu_out, ifc3.alu_cflag, ifc3.alu_zflag} = alu_model(ifc3.alu_a, ifc3.alu_b, ifc3.alu_sel);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic       g_busy(bit u3); return u3 ? busy3 : busy1; endfunction
  function automatic logic       g_done(bit u3); return u3 ? done3 : done1; endfunction
  function automatic logic [3:0] g_zc  (bit u3); return u3 ? zc3 : zc1; endfunction
  function automatic logic [2:0] g_sel (bit u3); return u3 ? ifc3.alu_sel : ifc1.alu_sel; endfunction
  function automatic logic [3:0] g_a   (bit u3); return u3 ? ifc3.alu_a : ifc1.alu_a; endfunction
  function automatic logic [3:0] g_b   (bit u3); return u3 ? ifc3.alu_b : ifc1.alu_b; endfunction
  function automatic logic [7:0] g_rdd (bit u3); return u3 ? rdd3 : rdd1; endfunction
  function automatic logic       g_rdc (bit u3); return u3 ? rdc3 : rdc1; endfunction
  function automatic logic       g_rdz (bit u3); return u3 ? rdz3 : rdz1; endfunction
  function automatic logic       g_rdv (bit u3); return u3 ? rdv3 : rdv1; endfunction

  typedef struct {
    logic [2:0] idx;
    logic [7:0] data;
    logic       c;
    logic       z;
  } exp_t;

  exp_t sb_q[$];

  typedef struct {
    bit         u3;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] mask;
    int         zc;
    int         done_cyc;
  } vec_t;

  vec_t vecs[8];

  // One sweep: push expectations, start, follow alu_sel and done, then read
  // the buffer back and pop/compare. poke_cyc>0 re-pulses start mid-sweep.
  task automatic run_vec(input bit u3, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] mask, input int exp_zc, input int exp_done,
                         input int poke_cyc);
    int         cyc, busy_cnt, run_len;
    bit         seen_done;
    logic [2:0] s, prev_sel;
    logic [2:0] obs[$];
    logic [2:0] want[$];
    logic [9:0] r;
    exp_t       e;

    for (int k = 0; k < 8; k++) begin
      if (mask[k]) begin
        r = alu_model(a, b, 3'(k));
        e.idx = 3'(k); e.data = r[9:2]; e.c = r[1]; e.z = r[0];
        sb_q.push_back(e);
        want.push_back(3'(k));
      end
    end

    @(negedge clk);
    a_in = a; b_in = b; op_mask = mask;
    if (u3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0; start3 = 1'b0;
    a_in = ~a; b_in = ~b; op_mask = ~mask;

    cyc = 0; busy_cnt = 0; run_len = 0; seen_done = 0; prev_sel = '0;
    while (!seen_done && cyc < 200) begin
      @(negedge clk);
      start1 = 1'b0; start3 = 1'b0;
      cyc++;
      if (g_busy(u3)) busy_cnt++;
      s = g_sel(u3);
      if (mask != 8'd0) begin
        if (cyc == 1) begin
          obs.push_back(s); run_len = 1;
        end else if (s != prev_sel) begin
          chk("sel_hold_len", 32'(run_len >= (u3 ? 4 : 3)), 32'd1);
          obs.push_back(s); run_len = 1;
        end else begin
          run_len++;
        end
      end
      prev_sel = s;
      if (g_done(u3)) seen_done = 1;
      if (cyc == poke_cyc) begin
        a_in = 4'd1; b_in = 4'd2; op_mask = 8'h01;
        if (u3) start3 = 1'b1; else start1 = 1'b1;
      end
    end
    start1 = 1'b0; start3 = 1'b0;

    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    else            chk("done_cycle", 32'(cyc), 32'(exp_done));
    chk("busy_cycles", 32'(busy_cnt), 32'(exp_done));
    chk("zero_cnt", 32'(g_zc(u3)), 32'(exp_zc));
    chk("alu_a_latched", 32'(g_a(u3)), 32'(a));
    chk("alu_b_latched", 32'(g_b(u3)), 32'(b));
    if (mask != 8'd0) begin
      chk("sel_count", 32'(obs.size()), 32'(want.size()));
      for (int i = 0; i < want.size(); i++)
        if (i < obs.size()) chk("sel_order", 32'(obs[i]), 32'(want[i]));
    end

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("done_single_pulse", 32'(g_done(u3)), 32'd0);
      chk("busy_after_done", 32'(g_busy(u3)), 32'd0);
    end

    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #1;
      if (mask[k]) begin
        if (sb_q.size() == 0) begin
          chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("rd_valid_set", 32'(g_rdv(u3)), 32'd1);
          chk("rd_data", 32'(g_rdd(u3)), 32'(e.data));
          chk("rd_cflag", 32'(g_rdc(u3)), 32'(e.c));
          chk("rd_zflag", 32'(g_rdz(u3)), 32'(e.z));
        end
      end else begin
        chk("rd_valid_clear", 32'(g_rdv(u3)), 32'd0);
        chk("rd_data_masked", 32'(g_rdd(u3)), 32'd0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    a_in = '0; b_in = '0; op_mask = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    chk("rst_sel1", 32'(ifc1.alu_sel), 32'd0);
    chk("rst_a1", 32'(ifc1.alu_a), 32'd0);
    chk("rst_b1", 32'(ifc1.alu_b), 32'd0);
    chk("rst_zc1", 32'(zc1), 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    chk("rst_zc3", 32'(zc3), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #0.5;
      chk("rst_rd_valid", 32'(rdv1), 32'd0);
      chk("rst_rd_data", 32'(rdd1), 32'd0);
    end

    vecs[0] = '{u3: 0, a: 4'hE, b: 4'hB, mask: 8'hFF, zc: 0, done_cyc: 25};
    vecs[1] = '{u3: 0, a: 4'h0, b: 4'h0, mask: 8'h41, zc: 2, done_cyc: 7};
    vecs[2] = '{u3: 0, a: 4'h9, b: 4'h3, mask: 8'h00, zc: 0, done_cyc: 1};
    vecs[3] = '{u3: 0, a: 4'h5, b: 4'h5, mask: 8'hA6, zc: 1, done_cyc: 13};
    vecs[4] = '{u3: 0, a: 4'h3, b: 4'h0, mask: 8'h08, zc: 0, done_cyc: 4};
    vecs[5] = '{u3: 0, a: 4'hF, b: 4'h1, mask: 8'h80, zc: 0, done_cyc: 4};
    vecs[6] = '{u3: 1, a: 4'hE, b: 4'hB, mask: 8'hFF, zc: 0, done_cyc: 41};
    vecs[7] = '{u3: 1, a: 4'h0, b: 4'h0, mask: 8'h41, zc: 2, done_cyc: 11};

    for (int i = 0; i < 8; i++) begin
      run_vec(vecs[i].u3, vecs[i].a, vecs[i].b, vecs[i].mask, vecs[i].zc, vecs[i].done_cyc, 0);
      $display("vector %0d: a=%h b=%h mask=%h settle=%0d", i, vecs[i].a, vecs[i].b,
               vecs[i].mask, vecs[i].u3 ? 3 : 1);
      if (i == 0) begin
        rd_idx = OP_ADD; #1 chk("ref_add", 32'(rdd1), 32'h19);
        rd_idx = OP_SUB; #1 chk("ref_sub", 32'(rdd1), 32'h03);
        rd_idx = OP_MUL; #1 chk("ref_mul", 32'(rdd1), 32'h9A);
        rd_idx = OP_DIV; #1 chk("ref_div", 32'(rdd1), 32'h01);
        rd_idx = OP_AND; #1 chk("ref_and", 32'(rdd1), 32'h0A);
        rd_idx = OP_OR;  #1 chk("ref_or",  32'(rdd1), 32'h0F);
      end
    end

    // Restart attempt at cycle 5 with different operands must be ignored.
    run_vec(0, 4'hE, 4'hB, 8'hFF, 0, 25, 5);
    $display("mid-sweep start: ignored restart, one done pulse");

    // Reset during WAIT of opcode 3 (cycle 11 with settle 1).
    @(negedge clk);
    a_in = 4'hE; b_in = 4'hB; op_mask = 8'hFF; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (11) @(negedge clk);
    chk("pre_rst_sel", 32'(ifc1.alu_sel), 32'd3);
    rd_idx = OP_MUL; #1 chk("mid_sweep_valid", 32'(rdv1), 32'd1);
    chk("mid_sweep_data", 32'(rdd1), 32'h9A);
    rd_idx = OP_DIV; #1 chk("mid_sweep_pending", 32'(rdv1), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy1), 32'd0);
    chk("abort_sel", 32'(ifc1.alu_sel), 32'd0);
    chk("abort_done", 32'(done1), 32'd0);
    chk("abort_zc", 32'(zc1), 32'd0);
    for (int k = 0; k < 8; k++) begin
      rd_idx = 3'(k);
      #0.5;
      chk("abort_rd_valid", 32'(rdv1), 32'd0);
    end
    $display("reset mid-sweep: sweep aborted");

    run_vec(0, 4'h6, 4'h2, 8'hFF, 0, 25, 0);
    $display("post-reset sweep: a=6 b=2 mask=ff");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
